fetch_pc_unit: RTL
==================

// Module: fetch_pc_unit
// PURPOSE
//   Instruction-fetch stage: owns the program counter and the IF/ID pipeline register.
//   Consumes the sign-extended, shifted branch offset from the B/CB immediate extenders
//   (via the branch-resolving stage) and forms the branch target, then redirects fetch.
//   Predict-not-taken; a taken branch flushes the wrong-path instruction in IF/ID.
// PARAMETERS
//   RESET_PC   64'h0            PC value loaded on reset
//   NOP_INSTR  32'hD503201F     ARM64 NOP encoding inserted as a bubble
// PORTS
//   clk            in   1   single clock, all state updates on rising edge
//   reset          in   1   synchronous, active-high
//   stall_f        in   1   hazard unit: hold PC and IF/ID this cycle
//   br_taken       in   1   resolved taken branch: redirect this cycle
//   br_pc          in   64  PC of the resolving branch instruction
//   br_imm         in   64  sign-extended, <<2 branch offset (imm_ext)
//   imem_addr      out  64  instruction memory address (= current PC)
//   imem_rdata     in   32  instruction word, async read, valid same cycle
//   if_id_instr    out  32  registered instruction to decode
//   if_id_pc       out  64  registered PC of if_id_instr
//   if_id_valid    out  1   1 = real instruction, 0 = bubble
//   redirect_cnt   out  16  number of taken-branch redirects (perf counter)
// BEHAVIOUR
//   - imem_addr = pc, combinational from the PC register; no other comb paths to outputs.
//   - Reset (sync, priority over all): pc<=RESET_PC; if_id_instr<=NOP_INSTR; if_id_pc<=0;
//     if_id_valid<=0; redirect_cnt<=0. br_taken/stall_f ignored while reset=1.
//   - Per edge, priority br_taken > stall_f > advance:
//     br_taken: pc <= {tgt[63:2],2'b00}, tgt = br_pc + br_imm (mod 2^64, carry dropped);
//       IF/ID <= bubble (NOP_INSTR, pc 0, valid 0); redirect_cnt <= redirect_cnt+1 (wraps).
//     stall_f (no br_taken): pc, if_id_* and redirect_cnt hold.
//     advance: pc <= pc+4 (mod 2^64); if_id_instr <= imem_rdata; if_id_pc <= pc; valid <= 1.
//   - Latency: instruction at address A appears on if_id_* one edge after imem_addr=A.
//   - First cycle after reset release: if_id_valid=0; valid rises on next edge if no stall.
//   - br_taken + stall_f same cycle: redirect wins (branch is older than stalled instr).
//   - Back-to-back br_taken: each cycle redirects and bubbles; counter increments each.
//   - Wrap: pc 64'hFFFF_FFFF_FFFF_FFFC +4 -> 0; redirect_cnt 16'hFFFF +1 -> 0.
//   - Target low bits forced to 00; no exception raised for misaligned br_pc.
//   - reset asserted mid-stall or mid-redirect: reset values next edge, no partial update.
// STRUCTURE
//   - cpu_pkg: ADDR_W=64, INSTR_W=32, NOP_INSTR constant, typedef if_id_t
//     {instr, pc, valid}; IF/ID register held as one if_id_t.
//   - Sub-module pc_adder (64-bit ripple add, a+b, carry dropped): two instances,
//     pc+64'd4 and br_pc+br_imm.
//   - Next-PC mux and IF/ID load mux in one always_comb; single always_ff for state.
// TESTING
//   1 reset 2 cycles, RESET_PC=0 -> imem_addr=0, if_id_valid=0, if_id_instr=32'hD503201F,
//     redirect_cnt=0.
//   2 imem_rdata = {16'hA5A5, addr[15:0]}, no stall, 3 edges -> imem_addr 4,8,C;
//     if_id_pc 0,4,8; if_id_instr A5A50000/04/08; valid 1 from 2nd edge.
//   3 at pc=0x10: br_taken, br_pc=0x8, br_imm=64'hFFFF_FFFF_FFFF_FFF8 -> next
//     imem_addr=0x0, if_id_valid=0, if_id_instr=NOP, redirect_cnt=1; next edge fetches 0x0.
//   4 at pc=0x20, stall_f high 2 cycles -> imem_addr=0x20, if_id_* unchanged;
//     release -> imem_addr=0x24, if_id_pc=0x20.
//   5 stall_f and br_taken same cycle (br_pc=0x40, br_imm=0x100) -> imem_addr=0x140,
//     bubble in IF/ID, counter +1.
//   6 br_pc=64'hFFFF_FFFF_FFFF_FFF8, br_imm=4 -> pc=..FFFC, next edge pc=0;
//     preload 65535 redirects, one more -> redirect_cnt=0; reset mid-stall -> all reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, constants and pipeline-register types for the fetch front end.
package cpu_pkg;

   localparam int unsigned ADDR_W  = 64;
   localparam int unsigned INSTR_W = 32;

   // ARM64 NOP, used to fill IF/ID whenever a bubble is inserted
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
      logic               valid;
   } if_id_t;

endpackage

// File: rtl/pc_adder.sv
// Ripple-carry adder for PC arithmetic; the carry out of the MSB is dropped.
module pc_adder
   import cpu_pkg::*;
(
   input  logic [ADDR_W-1:0] a,
   input  logic [ADDR_W-1:0] b,
   output logic [ADDR_W-1:0] sum
);

   logic [ADDR_W:0] carry;

   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = 1'b0;
      for (int i = 0; i < ADDR_W; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: program counter, IF/ID register and redirect counter.
// Predict-not-taken; a resolved taken branch redirects fetch and bubbles IF/ID.
module fetch_pc_unit #(
   parameter logic [cpu_pkg::ADDR_W-1:0]  RESET_PC  = 64'h0,
   parameter logic [cpu_pkg::INSTR_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_f,
   input  logic        br_taken,
   input  logic [63:0] br_pc,
   input  logic [63:0] br_imm,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_id_instr,
   output logic [63:0] if_id_pc,
   output logic        if_id_valid,
   output logic [15:0] redirect_cnt
);

   logic [63:0]     pc_q, pc_d;
   cpu_pkg::if_id_t if_id_q, if_id_d;
   logic [15:0]     cnt_q, cnt_d;
   logic [63:0]     pc_plus4;
   logic [63:0]     br_tgt;

   pc_adder u_pc_inc (
      .a   (pc_q),
      .b   (64'd4),
      .sum (pc_plus4)
   );

   pc_adder u_br_tgt (
      .a   (br_pc),
      .b   (br_imm),
      .sum (br_tgt)
   );

   // Redirect beats stall: the resolving branch is older than the stalled fetch.
   always_comb begin
      pc_d    = pc_q;
      if_id_d = if_id_q;
      cnt_d   = cnt_q;
      if (br_taken) begin
         pc_d          = {br_tgt[63:2], 2'b00};
         if_id_d.instr = NOP_INSTR;
         if_id_d.pc    = '0;
         if_id_d.valid = 1'b0;
         cnt_d         = cnt_q + 16'd1;
      end else if (!stall_f) begin
         pc_d          = pc_plus4;
         if_id_d.instr = imem_rdata;
         if_id_d.pc    = pc_q;
         if_id_d.valid = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         if_id_q.instr <= NOP_INSTR;
         if_id_q.pc    <= '0;
         if_id_q.valid <= 1'b0;
         cnt_q         <= '0;
      end else begin
         pc_q    <= pc_d;
         if_id_q <= if_id_d;
         cnt_q   <= cnt_d;
      end
   end

   assign imem_addr    = pc_q;
   assign if_id_instr  = if_id_q.instr;
   assign if_id_pc     = if_id_q.pc;
   assign if_id_valid  = if_id_q.valid;
   assign redirect_cnt = cnt_q;

endmodule
